// File: rtl/lane_mem_model_if.sv
// Request/response bundle between the LSU and the multi-lane memory model.
// The master side (LSU or bench) issues vector requests and consumes tagged
// responses; the slave side is the memory model.
interface lane_mem_model_if #(
    parameter int LANES  = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 7
);
    // request channel
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_gm_or_lds;
    logic                    req_rd;
    logic                    req_wr;
    logic [TAG_W-1:0]        req_tag;
    logic [LANES-1:0]        req_lane_mask;
    logic [LANES*ADDR_W-1:0] req_addr;
    logic [LANES*DATA_W-1:0] req_wr_data;

    // response channel
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [TAG_W-1:0]        rsp_tag;
    logic [LANES*DATA_W-1:0] rsp_rd_data;
    logic [LANES-1:0]        rsp_err;

    modport master (
        output req_valid, req_gm_or_lds, req_rd, req_wr, req_tag,
               req_lane_mask, req_addr, req_wr_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_tag, rsp_rd_data, rsp_err
    );

    modport slave (
        input  req_valid, req_gm_or_lds, req_rd, req_wr, req_tag,
               req_lane_mask, req_addr, req_wr_data, rsp_ready,
        output req_ready, rsp_valid, rsp_tag, rsp_rd_data, rsp_err
    );
endinterface

// File: rtl/lane_mem_model.sv
// Multi-lane data memory model: separate GM and LDS word banks, per-lane
// address checking and write masking, and a circular response queue that
// returns tagged results in accept order after a fixed latency.
module lane_mem_model #(
    parameter int LANES     = 64,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 7,
    parameter int GM_DEPTH  = 1024,
    parameter int LDS_DEPTH = 256,
    parameter int LATENCY   = 4,
    parameter int QDEPTH    = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    lane_mem_model_if.slave           bus,
    output logic [$clog2(QDEPTH):0]   outstanding_o
);
    localparam int GM_AW  = $clog2(GM_DEPTH);
    localparam int LDS_AW = $clog2(LDS_DEPTH);
    localparam int QA     = $clog2(QDEPTH);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int WIDX_W = ADDR_W - 2;

    localparam logic [WIDX_W-1:0] GM_LIMIT  = WIDX_W'(GM_DEPTH);
    localparam logic [WIDX_W-1:0] LDS_LIMIT = WIDX_W'(LDS_DEPTH);
    localparam logic [QA:0]       Q_FULL    = (QA+1)'(QDEPTH);
    localparam logic [CNT_W-1:0]  CD_LOAD   = CNT_W'(LATENCY - 1);

    // ------------------------------------------------------------------
    // Storage banks (never reset: contents survive a reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] gm_mem  [GM_DEPTH];
    logic [DATA_W-1:0] lds_mem [LDS_DEPTH];

    // ------------------------------------------------------------------
    // Response queue state
    // ------------------------------------------------------------------
    logic [TAG_W-1:0]        tag_q   [QDEPTH];
    logic [LANES*DATA_W-1:0] data_q  [QDEPTH];
    logic [LANES-1:0]        err_q   [QDEPTH];
    logic [CNT_W-1:0]        cd_q    [QDEPTH];
    logic [CNT_W-1:0]        cd_d    [QDEPTH];
    logic [QA-1:0]           wr_ptr_q, wr_ptr_d;
    logic [QA-1:0]           rd_ptr_q, rd_ptr_d;
    logic [QA:0]             count_q,  count_d;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                    req_ready;
    logic                    accept;
    logic                    retire;
    logic                    rsp_valid;
    logic                    is_rd;
    logic                    is_wr;
    logic                    is_both;
    logic [LANES-1:0]        lane_bad;
    logic [LANES-1:0]        lane_ok;
    logic [LANES*DATA_W-1:0] rd_data;
    logic [LANES*DATA_W-1:0] push_data;
    logic [LANES-1:0]        push_err;
    logic [GM_AW-1:0]        gm_idx  [LANES];
    logic [LDS_AW-1:0]       lds_idx [LANES];

    // Ready is derived from the registered count only, so a retire in the
    // same cycle does not free a slot until the next edge.
    assign req_ready = (count_q < Q_FULL);
    assign accept    = bus.req_valid & req_ready;
    assign is_rd     = bus.req_rd & ~bus.req_wr;
    assign is_wr     = bus.req_wr & ~bus.req_rd;
    assign is_both   = bus.req_rd & bus.req_wr;
    assign lane_ok   = bus.req_lane_mask & ~lane_bad;

    // Per-lane address split, range/alignment check and bank read
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [ADDR_W-1:0] addr;
        logic [WIDX_W-1:0] widx;

        assign addr          = bus.req_addr[gi*ADDR_W +: ADDR_W];
        assign widx          = addr[ADDR_W-1:2];
        assign gm_idx[gi]    = widx[GM_AW-1:0];
        assign lds_idx[gi]   = widx[LDS_AW-1:0];
        assign lane_bad[gi]  = (addr[1:0] != 2'b00) ||
                               (bus.req_gm_or_lds ? (widx >= GM_LIMIT)
                                                  : (widx >= LDS_LIMIT));
        assign rd_data[gi*DATA_W +: DATA_W] =
            lane_ok[gi] ? (bus.req_gm_or_lds ? gm_mem[gm_idx[gi]]
                                             : lds_mem[lds_idx[gi]])
                        : '0;
    end

    // Only plain reads return data; conflicting rd+wr flags every active
    // lane, ack-only requests flag nothing.
    assign push_data = is_rd ? rd_data : '0;
    assign push_err  = is_both         ? bus.req_lane_mask :
                       (is_rd | is_wr) ? (bus.req_lane_mask & lane_bad) :
                                         '0;

    // ------------------------------------------------------------------
    // Response side
    // ------------------------------------------------------------------
    assign rsp_valid = (count_q != '0) && (cd_q[rd_ptr_q] == '0);
    assign retire    = rsp_valid & bus.rsp_ready;

    assign bus.req_ready   = req_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.rsp_tag     = rsp_valid ? tag_q[rd_ptr_q]  : '0;
    assign bus.rsp_rd_data = rsp_valid ? data_q[rd_ptr_q] : '0;
    assign bus.rsp_err     = rsp_valid ? err_q[rd_ptr_q]  : '0;
    assign outstanding_o   = count_q;

    // Bank writes: ascending lane order lets the highest lane win a collision
    always_ff @(posedge clk_i) begin
        if (rst_ni && accept && is_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_ok[i]) begin
                    if (bus.req_gm_or_lds) begin
                        gm_mem[gm_idx[i]] <= bus.req_wr_data[i*DATA_W +: DATA_W];
                    end else begin
                        lds_mem[lds_idx[i]] <= bus.req_wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Queue payload capture at the write pointer on accept
    always_ff @(posedge clk_i) begin
        if (accept) begin
            tag_q[wr_ptr_q]  <= bus.req_tag;
            data_q[wr_ptr_q] <= push_data;
            err_q[wr_ptr_q]  <= push_err;
        end
    end

    // Next-state for pointers, count and countdowns. The pushed countdown
    // already includes this edge's decrement, so LATENCY=1 answers in the
    // cycle right after the accept.
    always_comb begin
        wr_ptr_d = wr_ptr_q + QA'(accept);
        rd_ptr_d = rd_ptr_q + QA'(retire);
        count_d  = count_q + (QA+1)'(accept) - (QA+1)'(retire);
        for (int i = 0; i < QDEPTH; i++) begin
            cd_d[i] = (cd_q[i] != '0) ? cd_q[i] - CNT_W'(1) : '0;
        end
        if (accept) begin
            cd_d[wr_ptr_q] = CD_LOAD;
        end
    end

    // Queue control registers; reset discards every pending response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                cd_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < QDEPTH; i++) begin
                cd_q[i] <= cd_d[i];
            end
        end
    end
endmodule

// File: tb/tb_lane_mem_model.sv
// Self-checking bench for lane_mem_model: directed scenarios with literal
// expectations followed by randomized traffic, all checked every cycle
// against a behavioural model (word arrays plus an expected-response queue).
module tb_lane_mem_model;
    localparam int LANES     = 64;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 7;
    localparam int GM_DEPTH  = 1024;
    localparam int LDS_DEPTH = 256;
    localparam int LATENCY   = 4;
    localparam int QDEPTH    = 4;
    localparam int OW        = $clog2(QDEPTH) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [OW-1:0] outstanding;

    lane_mem_model_if #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    lane_mem_model #(
        .LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .GM_DEPTH(GM_DEPTH), .LDS_DEPTH(LDS_DEPTH), .LATENCY(LATENCY), .QDEPTH(QDEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .bus           (bus),
        .outstanding_o (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0]        tag;
        logic [LANES*DATA_W-1:0] data;
        logic [LANES-1:0]        err;
        int                      t;
    } exp_t;

    exp_t                    sb[$];
    int unsigned             gm_m  [GM_DEPTH];
    int unsigned             lds_m [LDS_DEPTH];
    logic [LANES*DATA_W-1:0] cap_data [128];
    logic [LANES-1:0]        cap_err  [128];
    int                      ret_log[$];
    int                      ret_cyc[$];
    int                      checks = 0;
    int                      failures = 0;
    int                      cyc = 0;
    bit                      accepted = 1'b0;
    int                      last_accept_cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [LANES*DATA_W-1:0] got,
                            input logic [LANES*DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            for (int i = 0; i < LANES; i++) begin
                if (got[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) begin
                    $display("FAIL %s lane=%0d got=0x%0h exp=0x%0h at %0t", name, i,
                             got[i*DATA_W +: DATA_W], exp[i*DATA_W +: DATA_W], $time);
                    break;
                end
            end
        end
    endtask

    // Expected response for the request currently on the bus; applies writes
    // to the model banks.
    function automatic exp_t predict();
        exp_t        e;
        int unsigned a;
        int unsigned depth;
        bit          gm;
        e.tag  = bus.req_tag;
        e.data = '0;
        e.err  = '0;
        e.t    = cyc + 1;
        gm     = bus.req_gm_or_lds;
        depth  = gm ? GM_DEPTH : LDS_DEPTH;
        if (bus.req_rd && bus.req_wr) begin
            e.err = bus.req_lane_mask;
        end else if (bus.req_rd || bus.req_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.req_lane_mask[i]) begin
                    a = bus.req_addr[i*ADDR_W +: ADDR_W];
                    if ((a % 4) != 0 || (a / 4) >= depth) begin
                        e.err[i] = 1'b1;
                    end else if (bus.req_rd) begin
                        e.data[i*DATA_W +: DATA_W] = gm ? gm_m[a/4] : lds_m[a/4];
                    end else if (gm) begin
                        gm_m[a/4] = bus.req_wr_data[i*DATA_W +: DATA_W];
                    end else begin
                        lds_m[a/4] = bus.req_wr_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
        return e;
    endfunction

    // Runs at the falling edge: compare outputs, then decide what the next
    // rising edge retires and accepts.
    task automatic model_step();
        int sz;
        bit ev;
        accepted = 1'b0;
        if (!rst_n) begin
            sb.delete();
            chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            chk("rst_outstanding", 64'(outstanding), 64'd0);
            chk("rst_rsp_tag", 64'(bus.rsp_tag), 64'd0);
            chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
            chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
            chk_data("rst_rsp_data", bus.rsp_rd_data, '0);
            return;
        end
        sz = sb.size();
        ev = (sz > 0) && (cyc >= sb[0].t + LATENCY - 1);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        chk("outstanding", 64'(outstanding), 64'(sz));
        chk("req_ready", 64'(bus.req_ready), 64'(sz < QDEPTH));
        if (ev) begin
            chk("rsp_tag", 64'(bus.rsp_tag), 64'(sb[0].tag));
            chk("rsp_err", 64'(bus.rsp_err), 64'(sb[0].err));
            chk_data("rsp_data", bus.rsp_rd_data, sb[0].data);
            if (bus.rsp_ready) begin
                cap_data[sb[0].tag] = bus.rsp_rd_data;
                cap_err[sb[0].tag]  = bus.rsp_err;
                ret_log.push_back(int'(sb[0].tag));
                ret_cyc.push_back(cyc + 1);
                void'(sb.pop_front());
            end
        end
        if (bus.req_valid && sz < QDEPTH) begin
            sb.push_back(predict());
            accepted = 1'b1;
            last_accept_cyc = cyc + 1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_lanes();
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] addr, input logic [31:0] data);
        bus.req_addr[i*ADDR_W +: ADDR_W]    = addr;
        bus.req_wr_data[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic set_req(input bit gm, input bit rd, input bit wr, input int tag,
                           input logic [LANES-1:0] mask);
        bus.req_gm_or_lds = gm;
        bus.req_rd        = rd;
        bus.req_wr        = wr;
        bus.req_tag       = TAG_W'(tag);
        bus.req_lane_mask = mask;
    endtask

    task automatic send();
        int n = 0;
        bus.req_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 50);
        chk("send_accepted", 64'(accepted), 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [31:0] lane_of(input logic [LANES*DATA_W-1:0] v, input int i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [LANES-1:0] m;
        int               op;
        int unsigned      idx;
        bit               gm;

        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 0, '0);
        clear_lanes();
        for (int i = 0; i < GM_DEPTH; i++) gm_m[i] = 0;
        for (int i = 0; i < LDS_DEPTH; i++) lds_m[i] = 0;

        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();

        // Zero both banks so every word has a known value
        for (int k = 0; k < GM_DEPTH / LANES; k++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 32'((k*LANES + i) * 4), 32'd0);
            set_req(1'b1, 1'b0, 1'b1, 120, '1);
            send();
        end
        for (int k = 0; k < LDS_DEPTH / LANES; k++) begin
            for (int i = 0; i < LANES; i++) set_lane(i, 32'((k*LANES + i) * 4), 32'd0);
            set_req(1'b0, 1'b0, 1'b1, 121, '1);
            send();
        end
        drain();

        // Masked GM write then full read-back
        clear_lanes();
        set_lane(0, 32'h04, 32'd8);
        set_lane(1, 32'h14, 32'd7);
        set_lane(2, 32'h24, 32'd6);
        set_lane(3, 32'h34, 32'd5);
        set_req(1'b1, 1'b0, 1'b1, 1, 64'h5);
        send();
        set_req(1'b1, 1'b1, 1'b0, 2, 64'hF);
        send();
        drain();
        chk("t1_wr_err", 64'(cap_err[1]), 64'd0);
        chk_data("t1_wr_data", cap_data[1], '0);
        chk("t1_rd_l0", 64'(lane_of(cap_data[2], 0)), 64'd8);
        chk("t1_rd_l1", 64'(lane_of(cap_data[2], 1)), 64'd0);
        chk("t1_rd_l2", 64'(lane_of(cap_data[2], 2)), 64'd6);
        chk("t1_rd_l3", 64'(lane_of(cap_data[2], 3)), 64'd0);

        // LDS write at the same addresses leaves GM untouched
        set_lane(0, 32'h04, 32'h111);
        set_lane(1, 32'h14, 32'h222);
        set_lane(2, 32'h24, 32'h333);
        set_lane(3, 32'h34, 32'h444);
        set_req(1'b0, 1'b0, 1'b1, 3, 64'hF);
        send();
        set_req(1'b1, 1'b1, 1'b0, 4, 64'hF);
        send();
        set_req(1'b0, 1'b1, 1'b0, 5, 64'hF);
        send();
        drain();
        chk("t2_gm_l0", 64'(lane_of(cap_data[4], 0)), 64'd8);
        chk("t2_gm_l2", 64'(lane_of(cap_data[4], 2)), 64'd6);
        chk("t2_lds_l1", 64'(lane_of(cap_data[5], 1)), 64'h222);

        // Misaligned and out-of-range lanes are flagged and do not write
        clear_lanes();
        set_lane(0, 32'h44, 32'h99);
        set_lane(1, 32'h06, 32'h55);
        set_lane(2, 32'(4 * GM_DEPTH), 32'h66);
        set_req(1'b1, 1'b0, 1'b1, 6, 64'h7);
        send();
        clear_lanes();
        set_lane(0, 32'h04, 32'd0);
        set_lane(1, 32'h44, 32'd0);
        set_lane(2, 32'h00, 32'd0);
        set_req(1'b1, 1'b1, 1'b0, 7, 64'h7);
        send();
        drain();
        chk("t3_err", 64'(cap_err[6]), 64'h6);
        chk("t3_rd_l0", 64'(lane_of(cap_data[7], 0)), 64'd8);
        chk("t3_rd_l1", 64'(lane_of(cap_data[7], 1)), 64'h99);
        chk("t3_rd_l2", 64'(lane_of(cap_data[7], 2)), 64'd0);

        // Queue full with the consumer stalled, then in-order drain
        ret_log.delete();
        ret_cyc.delete();
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(1'b1, 1'b1, 1'b0, 21 + k, 64'h1);
            send();
        end
        set_req(1'b1, 1'b0, 1'b0, 25, 64'h1);
        bus.req_valid = 1'b1;
        repeat (6) cycle();
        chk("t4_req_ready", 64'(bus.req_ready), 64'd0);
        chk("t4_outstanding", 64'(outstanding), 64'd4);
        chk("t4_held_valid", 64'(bus.rsp_valid), 64'd1);
        chk("t4_held_tag", 64'(bus.rsp_tag), 64'd21);
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 20 && !accepted; n++) cycle();
        bus.req_valid = 1'b0;
        drain();
        chk("t4_ret_count", 64'(ret_log.size()), 64'd5);
        for (int k = 0; k < 5 && k < ret_log.size(); k++) begin
            chk("t4_ret_order", 64'(ret_log[k]), 64'(21 + k));
        end
        if (ret_cyc.size() > 0) begin
            chk("t4_accept_after_retire", 64'(last_accept_cyc - ret_cyc[0]), 64'd1);
        end

        // Same-word collision: the higher lane wins
        clear_lanes();
        set_lane(0, 32'h10, 32'hA);
        set_lane(63, 32'h10, 32'hB);
        m = '0;
        m[0] = 1'b1;
        m[63] = 1'b1;
        set_req(1'b1, 1'b0, 1'b1, 30, m);
        send();
        set_req(1'b1, 1'b1, 1'b0, 31, m);
        send();
        drain();
        chk("t5_l0", 64'(lane_of(cap_data[31], 0)), 64'hB);
        chk("t5_l63", 64'(lane_of(cap_data[31], 63)), 64'hB);

        // Reset with responses pending; memory survives
        bus.rsp_ready = 1'b0;
        clear_lanes();
        set_lane(0, 32'h10, 32'd0);
        for (int k = 0; k < 3; k++) begin
            set_req(1'b1, 1'b1, 1'b0, 40 + k, 64'h1);
            send();
        end
        repeat (2) cycle();
        chk("t6_pre_outstanding", 64'(outstanding), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("t6_rst_outstanding", 64'(outstanding), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        cycle();
        set_lane(1, 32'h04, 32'd0);
        set_req(1'b1, 1'b1, 1'b0, 43, 64'h3);
        send();
        drain();
        chk("t6_keep_0x10", 64'(lane_of(cap_data[43], 0)), 64'hB);
        chk("t6_keep_0x04", 64'(lane_of(cap_data[43], 1)), 64'd8);

        // Randomized traffic against the model
        for (int k = 0; k < 800; k++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            if (!bus.req_valid || accepted) begin
                gm = bit'($urandom_range(0, 1));
                op = $urandom_range(0, 19);
                set_req(gm, (op < 9) || (op == 18), ((op >= 9) && (op < 18)) || (op == 18),
                        $urandom_range(0, 127), {$urandom, $urandom});
                for (int i = 0; i < LANES; i++) begin
                    idx = $urandom_range(0, 63);
                    case ($urandom_range(0, 15))
                        0:       set_lane(i, 32'(idx * 4 + $urandom_range(1, 3)), $urandom);
                        1:       set_lane(i, 32'(((gm ? GM_DEPTH : LDS_DEPTH) + idx) * 4), $urandom);
                        default: set_lane(i, 32'(idx * 4), $urandom);
                    endcase
                end
                bus.req_valid = ($urandom_range(0, 4) != 0);
            end
            cycle();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
